mode_sequencer: RTL and testbench
=================================

Name: mode_sequencer

Overview:
- Control stage directly upstream of the vector processor; it drives the processor's reset and its six one-hot mode lines (xor, rshift, lshift, ecae, dcae, mul).
- Accepts encoded operation requests over a valid/ready handshake.
- For each accepted request it parks the processor in reset, releases it with exactly one mode line asserted, and waits for completion or timeout.
- Reports completion, timeout and illegal-code status to the host/test logic.

Parameters:
RST_CYCLES, 2, number of cycles proc_reset is held high before a run; must be >= 1.
TIMEOUT, 1000, maximum RUN cycles before forced finish; 0 disables the timeout.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_mode  input  3  operation code: 0 xor, 1 rshift, 2 lshift, 3 ecae, 4 dcae, 5 mul, 6-7 illegal
req_ready  output  1  block can accept a request
proc_done  input  1  processor reports end of operation (level or pulse)
proc_reset  output  1  reset to processor, active-high
mode_xor, mode_rshift, mode_lshift, mode_ecae, mode_dcae, mode_mul  output  1 each  processor mode lines, at most one high
busy  output  1  high in PRST, RUN or FINISH
done  output  1  one-cycle pulse, operation finished
timed_out  output  1  one-cycle pulse with done when finish was caused by timeout
err  output  1  one-cycle pulse, illegal code accepted

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- All outputs are registered.
- Reset values: state IDLE; proc_reset=1; all mode_*=0; req_ready=0; busy=0; done=0; timed_out=0; err=0; counters=0.
- States: IDLE, PRST, RUN, FINISH.
- IDLE:
  - req_ready=1, proc_reset=1, modes=0.
  - Accept occurs on req_valid&&req_ready at edge T.
  - Legal code: latch code; next state PRST.
  - Illegal code (6, 7): err=1 during cycle T+1; stay IDLE; req_ready stays 1.
- PRST:
  - proc_reset=1, modes=0, req_ready=0, busy=1.
  - Lasts exactly RST_CYCLES cycles (T+1 .. T+RST_CYCLES), then RUN.
  - proc_done is ignored in this state.
- RUN:
  - First RUN cycle is T+RST_CYCLES+1.
  - proc_reset=0; exactly the latched mode line=1; busy=1.
  - The run counter starts at 0 and increments each RUN cycle.
  - proc_done=1 -> FINISH with timed_out=0.
  - Otherwise, with TIMEOUT!=0 and counter==TIMEOUT-1 -> FINISH with timed_out=1.
  - proc_done and timeout in the same cycle: done wins, timed_out=0.
- FINISH:
  - Lasts one cycle; modes=0; proc_reset=1; done=1; timed_out per cause; busy=1.
  - Next state IDLE; req_ready=1 from the following cycle.
- Requests presented while req_ready=0 are not accepted and not lost: the requester must hold req_valid.
- Mode lines never change mid-RUN. At most one mode line is high in any cycle, and none is high while proc_reset=1.
- Reset asserted mid-operation, at any state: the next edge gives reset values, all mode lines drop, and proc_reset rises. No done pulse is generated.
- Counter width: $clog2(max(RST_CYCLES,TIMEOUT)+1). The run counter saturates; it never wraps.
- Minimum request-to-request spacing: RST_CYCLES+3 cycles, with proc_done arriving on the first RUN cycle.

Test Plan:
1. Reset for 2 cycles, then release -> proc_reset=1, modes=0, req_ready=1 in the first cycle after release; busy=0.
2. req_mode=0 accepted at T, proc_done pulsed at T+5 -> proc_reset=1 at T+1..T+2; mode_xor=1 and proc_reset=0 at T+3..T+5; done=1, timed_out=0 at T+6; req_ready=1 at T+7.
3. req_mode=5 with TIMEOUT=8 and proc_done held 0 -> mode_mul high for exactly 8 cycles (T+3..T+10); done=1 and timed_out=1 at T+11.
4. req_mode=7 -> err=1 for one cycle at T+1; no mode line rises; busy=0 throughout. Follow with req_mode=3 -> mode_ecae runs normally.
5. Hold req_valid with req_mode=4 while busy with a mode=1 run -> the second request is accepted only on the cycle req_ready returns. mode_rshift and mode_dcae are never high together.
6. Assert reset during RUN (mode_lshift=1) -> on the next edge mode_lshift=0, proc_reset=1, done=0, busy=0. In the same cycle proc_done=1 with counter==TIMEOUT-1 -> timed_out=0.

Source files
------------

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - sequences vector-processor reset and one-hot mode lines per accepted request
module mode_sequencer #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_mode,
  output logic       req_ready,
  input  logic       proc_done,
  output logic       proc_reset,
  output logic       mode_xor,
  output logic       mode_rshift,
  output logic       mode_lshift,
  output logic       mode_ecae,
  output logic       mode_dcae,
  output logic       mode_mul,
  output logic       busy,
  output logic       done,
  output logic       timed_out,
  output logic       err
);

  localparam int CNT_MAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {S_IDLE, S_PRST, S_RUN, S_FINISH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    code_q, code_d;
  logic [5:0]    modes_q, modes_d;
  logic          ready_q, ready_d;
  logic          prst_q, prst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          to_q, to_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      modes_q <= '0;
      ready_q <= 1'b0;
      prst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      modes_q <= modes_d;
      ready_q <= ready_d;
      prst_q  <= prst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          if (req_mode <= 3'd5) begin
            code_d  = req_mode;
            cnt_d   = '0;
            state_d = S_PRST;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PRST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // Completion takes priority over a coincident timeout.
        if (proc_done) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else if (TIMEOUT != 0 && cnt_q == RUN_LAST) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          to_d    = 1'b1;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Level outputs are registered copies of what the next state implies.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    prst_d  = (state_d != S_RUN);
    modes_d = (state_d == S_RUN) ? (6'b000001 << code_d) : 6'b000000;
  end

  assign req_ready   = ready_q;
  assign proc_reset  = prst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timed_out   = to_q;
  assign err         = err_q;
  assign mode_xor    = modes_q[0];
  assign mode_rshift = modes_q[1];
  assign mode_lshift = modes_q[2];
  assign mode_ecae   = modes_q[3];
  assign mode_dcae   = modes_q[4];
  assign mode_mul    = modes_q[5];

endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - scoreboard bench for mode_sequencer
module tb_mode_sequencer;

  localparam int R  = 2;
  localparam int TO = 8;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_mode;
  logic       req_ready;
  logic       proc_done;
  logic       proc_reset;
  logic       mode_xor, mode_rshift, mode_lshift, mode_ecae, mode_dcae, mode_mul;
  logic       busy, done, timed_out, err;

  mode_sequencer #(.RST_CYCLES(R), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_mode(req_mode), .req_ready(req_ready),
    .proc_done(proc_done), .proc_reset(proc_reset),
    .mode_xor(mode_xor), .mode_rshift(mode_rshift), .mode_lshift(mode_lshift),
    .mode_ecae(mode_ecae), .mode_dcae(mode_dcae), .mode_mul(mode_mul),
    .busy(busy), .done(done), .timed_out(timed_out), .err(err)
  );

  typedef struct {
    bit         is_err;
    logic [5:0] mv;
    int         start;
    int         fin;
    bit         to;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         cyc = 0;
  int         checks = 0;
  int         passed = 0;
  logic [5:0] mv;
  bit         run_on = 0;
  logic [5:0] run_mv = '0;
  int         run_start = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_run(input logic [2:0] m, input int t, input int j);
    exp_t x;
    x.is_err = 1'b0;
    x.mv     = 6'b000001 << m;
    x.start  = t + R;
    x.fin    = (j < 0) ? t + R + TO : t + R + j + 1;
    x.to     = (j < 0);
    q.push_back(x);
  endtask

  task automatic push_err(input int t);
    exp_t x;
    x.is_err = 1'b1;
    x.mv     = '0;
    x.start  = 0;
    x.fin    = t;
    x.to     = 1'b0;
    q.push_back(x);
  endtask

  // j: RUN cycle index of proc_done, -1 timeout, -2 no expectation.
  task automatic issue(input logic [2:0] m, input int j, output int t);
    int n;
    n = 0;
    req_mode  = m;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", int'(req_ready), 1);
    t = cyc + 1;
    if (m > 3'd5) push_err(t);
    else if (j >= -1) push_run(m, t, j);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_done(input int t, input int j);
    wait_cyc(t + R + j);
    proc_done = 1'b1;
    @(negedge clk);
    proc_done = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    mv = {mode_mul, mode_dcae, mode_ecae, mode_lshift, mode_rshift, mode_xor};
    chk("mode_onehot", int'($onehot0(mv) && !(proc_reset && mv != 6'd0)), 1);
    chk("to_without_done", int'(timed_out && !done), 0);
    if (reset) begin
      run_on = 1'b0;
    end else begin
      if (mv != 6'd0) begin
        if (!run_on) begin
          run_on    = 1'b1;
          run_mv    = mv;
          run_start = cyc;
        end else begin
          chk("mode_stable", int'(mv), int'(run_mv));
        end
      end
      if (done) begin
        if (q.size() == 0) chk("done_unexpected", int'(done), 0);
        else begin
          e = q.pop_front();
          chk("done_kind", int'(e.is_err), 0);
          chk("done_cycle", cyc, e.fin);
          chk("run_mode", int'(run_mv), int'(e.mv));
          chk("run_start", run_start, e.start);
          chk("timed_out", int'(timed_out), int'(e.to));
          chk("done_busy", int'(busy), 1);
          chk("done_proc_reset", int'(proc_reset), 1);
        end
        run_on = 1'b0;
      end
      if (err) begin
        if (q.size() == 0) chk("err_unexpected", int'(err), 0);
        else begin
          e = q.pop_front();
          chk("err_kind", int'(e.is_err), 1);
          chk("err_cycle", cyc, e.fin);
          chk("err_busy", int'(busy), 0);
          chk("err_ready", int'(req_ready), 1);
        end
      end
    end
  end

  initial begin
    int t, t1, t2, n;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_mode  = 3'd0;
    proc_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_proc_reset", int'(proc_reset), 1);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_modes", int'(mv), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", int'(req_ready), 1);
    chk("idle_proc_reset", int'(proc_reset), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_modes", int'(mv), 0);

    issue(3'd0, 2, t);
    pulse_done(t, 2);
    drain();

    issue(3'd5, -1, t);
    drain();

    issue(3'd7, 0, t);
    issue(3'd6, 0, t);
    issue(3'd3, 0, t);
    pulse_done(t, 0);
    drain();

    // Second request held while busy; accepted only when ready returns.
    issue(3'd1, 0, t1);
    req_mode  = 3'd4;
    req_valid = 1'b1;
    t2 = t1 + R + 3;
    push_run(3'd4, t2, 0);
    pulse_done(t1, 0);
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    pulse_done(t2, 0);
    drain();

    // Reset mid-RUN coinciding with proc_done and the timeout cycle.
    issue(3'd2, -2, t);
    wait_cyc(t + R + TO - 1);
    chk("lshift_running", int'(mode_lshift), 1);
    proc_done = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    chk("mid_rst_lshift", int'(mode_lshift), 0);
    chk("mid_rst_proc_reset", int'(proc_reset), 1);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_timed_out", int'(timed_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    reset     = 1'b0;
    proc_done = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(req_ready), 1);

    issue(3'd4, 1, t);
    pulse_done(t, 1);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
